rr_priority_arbiter: RTL and testbench

Registered, parametrised request arbiter built on priority encoding. It accepts up to REQ_WIDTH simultaneous requests and issues one registered one-hot grant plus its binary index. The grant is held until it is released. Selection is either fixed-priority or round-robin, chosen by parameter. It sits between bus masters (DMA, UART, GPIO sequencers) and a shared resource in the lab SoC.

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_pick.sv | 43 ++++
 rtl/rr_priority_arbiter.sv | 104 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the request arbiter.
// Pure declarations: no latency and no flow control of its own.
package arb_pkg;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner pick: fixed-priority or wrap-around scan from ptr.
// Zero latency; no backpressure, the caller decides when to take the result.
module arb_pick
   import arb_pkg::*;
#(
   parameter  int REQ_WIDTH = 16,
   localparam int BIN_WIDTH = $clog2(REQ_WIDTH)
) (
   input  logic [REQ_WIDTH-1:0] req,
   input  logic [BIN_WIDTH-1:0] ptr,
   input  logic                 mode,
   input  logic [REQ_WIDTH-1:0] mask,
   output logic [BIN_WIDTH-1:0] win_bin,
   output logic [REQ_WIDTH-1:0] win_oh,
   output logic                 any_vld
);

   logic [REQ_WIDTH-1:0]   eff_req;
   logic [REQ_WIDTH-1:0]   lo_keep;
   logic [2*REQ_WIDTH-1:0] dbl_req;

   always_comb begin
      eff_req = req & ~mask;
      for (int i = 0; i < REQ_WIDTH; i++) begin
         lo_keep[i] = (mode == ARB_RR) ? (i >= int'(ptr)) : 1'b1;
      end
      // Lower copy starts at ptr, upper copy supplies the wrapped-around indices.
      dbl_req = {eff_req, eff_req & lo_keep};
      win_bin = '0;
      any_vld = 1'b0;
      for (int i = 2*REQ_WIDTH-1; i >= 0; i--) begin
         if (dbl_req[i]) begin
            any_vld = 1'b1;
            win_bin = BIN_WIDTH'(i % REQ_WIDTH);
         end
      end
      win_oh = '0;
      if (any_vld) begin
         win_oh[win_bin] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter: one-hot grant held until release or owner drops its request.
// Request-to-grant latency 1 cycle; back-to-back handover with no idle cycle.
module rr_priority_arbiter
   import arb_pkg::*;
#(
   parameter  int REQ_WIDTH = 16,
   parameter  int MODE      = 1,
   localparam int BIN_WIDTH = $clog2(REQ_WIDTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [REQ_WIDTH-1:0] i_req,
   input  logic                 i_release,
   output logic [REQ_WIDTH-1:0] o_grant,
   output logic [BIN_WIDTH-1:0] o_grant_bin,
   output logic                 o_active
);

   localparam logic                 MODE_SEL = (MODE == 1) ? ARB_RR : ARB_FIXED;
   localparam logic [BIN_WIDTH-1:0] LAST_IDX = BIN_WIDTH'(REQ_WIDTH - 1);

   arb_state_t           state_q, state_d;
   logic [BIN_WIDTH-1:0] ptr_q, ptr_d;
   logic [REQ_WIDTH-1:0] grant_q, grant_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic                 active_q, active_d;

   logic [BIN_WIDTH-1:0] pick_bin;
   logic [REQ_WIDTH-1:0] pick_oh;
   logic                 pick_any;
   logic                 owner_req;

   // grant_q is zero while idle, so it doubles as the owner mask.
   arb_pick #(.REQ_WIDTH(REQ_WIDTH)) u_pick (
      .req     (i_req),
      .ptr     (ptr_q),
      .mode    (MODE_SEL),
      .mask    (grant_q),
      .win_bin (pick_bin),
      .win_oh  (pick_oh),
      .any_vld (pick_any)
   );

   assign owner_req = i_req[bin_q];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      bin_d    = bin_q;
      active_d = active_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d  = ARB_GRANT;
               grant_d  = pick_oh;
               bin_d    = pick_bin;
               active_d = 1'b1;
            end
         end
         ARB_GRANT: begin
            if (i_release || !owner_req) begin
               ptr_d = (bin_q == LAST_IDX) ? '0 : bin_q + BIN_WIDTH'(1);
               if (pick_any) begin
                  grant_d = pick_oh;
                  bin_d   = pick_bin;
               end else if (!owner_req) begin
                  state_d  = ARB_IDLE;
                  grant_d  = '0;
                  bin_d    = '0;
                  active_d = 1'b0;
               end
            end
         end
         default: begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            bin_d    = '0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         bin_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         bin_q    <= bin_d;
         active_q <= active_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_grant_bin = bin_q;
   assign o_active    = active_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed table vectors on a round-robin and a fixed-priority instance,
// followed by a random run against a reference model.
module tb_rr_priority_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1 = 1'b1, rel1 = 1'b0, act1;
   logic [15:0] req1 = 16'h0, g1;
   logic [3:0]  b1;
   logic        rst0 = 1'b1, rel0 = 1'b0, act0;
   logic [15:0] req0 = 16'h0, g0;
   logic [3:0]  b0;

   rr_priority_arbiter #(.REQ_WIDTH(16), .MODE(1)) dut_rr (
      .i_clk(clk), .i_rst(rst1), .i_req(req1), .i_release(rel1),
      .o_grant(g1), .o_grant_bin(b1), .o_active(act1)
   );

   rr_priority_arbiter #(.REQ_WIDTH(16), .MODE(0)) dut_fp (
      .i_clk(clk), .i_rst(rst0), .i_req(req0), .i_release(rel0),
      .o_grant(g0), .o_grant_bin(b0), .o_active(act0)
   );

   typedef struct {
      logic        fp;
      logic        rst;
      logic [15:0] req;
      logic        rel;
      logic [15:0] g;
      logic [3:0]  b;
      logic        a;
   } vec_t;

   vec_t tbl[$];
   int   vecs = 0;
   int   errs = 0;

   task automatic add(input logic fp, input logic rst, input logic [15:0] req,
                      input logic rel, input logic [15:0] g, input logic [3:0] b,
                      input logic a);
      vec_t v;
      v.fp = fp; v.rst = rst; v.req = req; v.rel = rel; v.g = g; v.b = b; v.a = a;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] g, input logic [3:0] b,
                        input logic a, input logic [15:0] eg, input logic [3:0] eb,
                        input logic ea);
      vecs++;
      if (g !== eg || b !== eb || a !== ea) begin
         errs++;
         $display("FAIL %s: got grant=%h bin=%0d active=%b, want grant=%h bin=%0d active=%b",
                  name, g, b, a, eg, eb, ea);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      if (v.fp) begin
         rst0 = v.rst; req0 = v.req; rel0 = v.rel;
      end else begin
         rst1 = v.rst; req1 = v.req; rel1 = v.rel;
      end
      @(posedge clk);
      #1;
      if (v.fp) check($sformatf("fp_vec%0d", idx), g0, b0, act0, v.g, v.b, v.a);
      else      check($sformatf("rr_vec%0d", idx), g1, b1, act1, v.g, v.b, v.a);
   endtask

   function automatic int rr_pick(input logic [15:0] req, input int start, input int skip);
      for (int k = 0; k < 16; k++) begin
         int i;
         i = (start + k) % 16;
         if (req[i] && i != skip) return i;
      end
      return -1;
   endfunction

   initial begin
      // Reset held with every request asserted.
      add(0, 1, 16'hFFFF, 0, 16'h0000, 0, 0);
      add(0, 1, 16'hFFFF, 0, 16'h0000, 0, 0);
      add(0, 1, 16'hFFFF, 0, 16'h0000, 0, 0);
      add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
      // Single request, then drop.
      add(0, 0, 16'h0010, 0, 16'h0010, 4, 1);
      add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
      // Round-robin rotation 0,2,15,0,2 from a fresh pointer.
      add(0, 1, 16'h0000, 0, 16'h0000, 0, 0);
      add(0, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(0, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(0, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(0, 0, 16'h8005, 1, 16'h0004, 2, 1);
      add(0, 0, 16'h8005, 0, 16'h0004, 2, 1);
      add(0, 0, 16'h8005, 0, 16'h0004, 2, 1);
      add(0, 0, 16'h8005, 1, 16'h8000, 15, 1);
      add(0, 0, 16'h8005, 0, 16'h8000, 15, 1);
      add(0, 0, 16'h8005, 0, 16'h8000, 15, 1);
      add(0, 0, 16'h8005, 1, 16'h0001, 0, 1);
      add(0, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(0, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(0, 0, 16'h8005, 1, 16'h0004, 2, 1);
      // No pre-emption of owner 5 by requester 1.
      add(0, 1, 16'h0000, 0, 16'h0000, 0, 0);
      add(0, 0, 16'h0020, 0, 16'h0020, 5, 1);
      add(0, 0, 16'h0022, 0, 16'h0020, 5, 1);
      add(0, 0, 16'h0022, 0, 16'h0020, 5, 1);
      add(0, 0, 16'h0022, 1, 16'h0002, 1, 1);
      add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
      // Release while idle is ignored; reset mid-grant; pointer restarts at 0.
      add(0, 0, 16'h0000, 1, 16'h0000, 0, 0);
      add(0, 0, 16'h0002, 0, 16'h0002, 1, 1);
      add(0, 1, 16'h0002, 0, 16'h0000, 0, 0);
      add(0, 0, 16'h0003, 0, 16'h0001, 0, 1);
      // Lone owner re-granted on release; newly raised request eligible with release.
      add(0, 0, 16'h0001, 1, 16'h0001, 0, 1);
      add(0, 0, 16'h0009, 1, 16'h0008, 3, 1);
      add(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
      // Fixed priority: owner masked on release, lowest other index wins.
      add(1, 1, 16'h0000, 0, 16'h0000, 0, 0);
      add(1, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(1, 0, 16'h8005, 1, 16'h0004, 2, 1);
      add(1, 0, 16'h8005, 1, 16'h0001, 0, 1);
      add(1, 0, 16'h8005, 0, 16'h0001, 0, 1);
      add(1, 0, 16'h8004, 0, 16'h0004, 2, 1);
      add(1, 0, 16'h8000, 0, 16'h8000, 15, 1);
      add(1, 0, 16'h0000, 0, 16'h0000, 0, 0);

      #1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Random run on the round-robin instance against a reference model.
      begin
         vec_t v;
         int   m_act, m_owner, m_ptr, w;
         logic [15:0] eg;
         v.fp = 0; v.rst = 1; v.req = 16'h0; v.rel = 0; v.g = 0; v.b = 0; v.a = 0;
         apply(v, 999);
         m_act = 0; m_owner = 0; m_ptr = 0;
         for (int n = 0; n < 100; n++) begin
            logic [15:0] r;
            logic        rl;
            r  = 16'($urandom & $urandom);
            rl = ($urandom_range(0, 3) == 0);
            if (m_act == 0) begin
               w = rr_pick(r, m_ptr, -1);
               if (w >= 0) begin m_act = 1; m_owner = w; end
            end else if (rl || !r[m_owner]) begin
               w = rr_pick(r, m_ptr, m_owner);
               m_ptr = (m_owner + 1) % 16;
               if (w >= 0) m_owner = w;
               else if (!r[m_owner]) begin m_act = 0; m_owner = 0; end
            end
            eg = m_act ? (16'h1 << m_owner) : 16'h0;
            rst1 = 0; req1 = r; rel1 = rl;
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", n), g1, b1, act1, eg, 4'(m_owner), 1'(m_act));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
